// File: rtl/sram_ctrl_pkg.sv
// Shared defaults and FSM state type for the SRAM port controller.
package sram_ctrl_pkg;

  localparam int unsigned ADDR_W = 7;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 128;

  typedef enum logic [0:0] {
    INIT,
    RUN
  } state_e;

endpackage

// File: rtl/resp_fifo2.sv
// Two-entry in-order response buffer with valid/ready pop and occupancy output.
module resp_fifo2 #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] push_data_i,
  input  logic             pop_ready_i,
  output logic             valid_o,
  output logic [Width-1:0] data_o,
  output logic [1:0]       occ_o
);

  logic [Width-1:0] mem_q [2];
  logic             rd_ptr_q, wr_ptr_q;
  logic [1:0]       cnt_q, cnt_d;
  logic             pop;

  assign valid_o = (cnt_q != 2'd0);
  assign pop     = valid_o & pop_ready_i;
  assign occ_o   = cnt_q;
  // Data is forced to zero whenever nothing is presented.
  assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;

  always_comb begin
    cnt_d = cnt_q + {1'b0, push_i} - {1'b0, pop};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
      end
      wr_ptr_q <= wr_ptr_q ^ push_i;
      rd_ptr_q <= rd_ptr_q ^ pop;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/sram_port_ctrl.sv
// Request/response front end for a single-port synchronous SRAM with post-reset clear.
module sram_port_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned       ADDR_W     = sram_ctrl_pkg::ADDR_W,
  parameter int unsigned       DATA_W     = sram_ctrl_pkg::DATA_W,
  parameter int unsigned       DEPTH      = sram_ctrl_pkg::DEPTH,
  parameter bit                INIT_EN    = 1'b1,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_req_valid,
  output logic              io_req_ready,
  input  logic              io_req_write,
  input  logic [ADDR_W-1:0] io_req_addr,
  input  logic [DATA_W-1:0] io_req_data,
  output logic              io_resp_valid,
  input  logic              io_resp_ready,
  output logic [DATA_W-1:0] io_resp_data,
  output logic              io_init_busy,
  output logic              io_sram_csb0,
  output logic              io_sram_web0,
  output logic [ADDR_W-1:0] io_sram_addr0,
  output logic [DATA_W-1:0] io_sram_din0,
  input  logic [DATA_W-1:0] io_sram_dout0
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
  logic              inflight_q, inflight_d;
  logic              fire, resp_pop;
  logic [1:0]        fifo_occ;
  logic [2:0]        pending;

  assign fire     = io_req_valid & io_req_ready;
  assign resp_pop = io_resp_valid & io_resp_ready;

  // Counts reads that will still occupy a FIFO slot after this cycle's pop.
  assign pending = {1'b0, fifo_occ} + {2'b0, inflight_q} - {2'b0, resp_pop};

  always_comb begin
    io_req_ready = ~reset & (state_q == RUN) & (pending < 3'd2);
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      if (INIT_EN) begin
        state_q <= INIT;
      end else begin
        state_q <= RUN;
      end
      init_cnt_q <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      inflight_q <= inflight_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    inflight_d = fire & ~io_req_write;
    case (state_q)
      INIT: begin
        init_cnt_d = init_cnt_q + ADDR_W'(1);
        if (init_cnt_q == LastAddr) begin
          state_d    = RUN;
          init_cnt_d = '0;
        end
      end
      default: ;
    endcase
  end

  // Output logic: the SRAM port is idle unless clearing or a request fires.
  always_comb begin
    io_sram_csb0  = 1'b1;
    io_sram_web0  = 1'b1;
    io_sram_addr0 = '0;
    io_sram_din0  = '0;
    io_init_busy  = 1'b0;
    if (!reset) begin
      case (state_q)
        INIT: begin
          io_sram_csb0  = 1'b0;
          io_sram_web0  = 1'b0;
          io_sram_addr0 = init_cnt_q;
          io_sram_din0  = INIT_VALUE;
          io_init_busy  = 1'b1;
        end
        default: begin
          if (fire) begin
            io_sram_csb0  = 1'b0;
            io_sram_web0  = ~io_req_write;
            io_sram_addr0 = io_req_addr;
            io_sram_din0  = io_req_write ? io_req_data : '0;
          end
        end
      endcase
    end
  end

  // SRAM read data is valid the cycle after the read fires; capture it then.
  resp_fifo2 #(
    .Width(DATA_W)
  ) u_resp_fifo (
    .clk_i      (clock),
    .rst_i      (reset),
    .push_i     (inflight_q),
    .push_data_i(io_sram_dout0),
    .pop_ready_i(io_resp_ready),
    .valid_o    (io_resp_valid),
    .data_o     (io_resp_data),
    .occ_o      (fifo_occ)
  );

endmodule

// File: tb/tb_sram_port_ctrl.sv
// Scoreboard bench for sram_port_ctrl with a behavioural synchronous SRAM model.
module tb_sram_port_ctrl;

  localparam int AW = 7;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b1;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_data = '0;
  logic          req_ready, resp_valid, init_busy, csb0, web0;
  logic [DW-1:0] resp_data, din0, dout0;
  logic [AW-1:0] addr0;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int fire_first = 0, fire_last = 0;
  logic [DW-1:0] exp_q[$];
  int            pop_cyc_q[$];
  logic [DW-1:0] sram_mem[128];

  sram_port_ctrl u_dut (
    .clock        (clk),
    .reset        (reset),
    .io_req_valid (req_valid),
    .io_req_ready (req_ready),
    .io_req_write (req_write),
    .io_req_addr  (req_addr),
    .io_req_data  (req_data),
    .io_resp_valid(resp_valid),
    .io_resp_ready(resp_ready),
    .io_resp_data (resp_data),
    .io_init_busy (init_busy),
    .io_sram_csb0 (csb0),
    .io_sram_web0 (web0),
    .io_sram_addr0(addr0),
    .io_sram_din0 (din0),
    .io_sram_dout0(dout0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (!csb0) begin
      if (!web0) sram_mem[addr0] <= din0;
      else       dout0 <= sram_mem[addr0];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pop expected data whenever the DUT hands over a response.
  always @(negedge clk) begin
    if (!reset) begin
      if (resp_valid && resp_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_resp", {32'h0, resp_data}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          check("resp_data", {32'h0, resp_data}, {32'h0, exp_q.pop_front()});
        end
        pop_cyc_q.push_back(cyc);
      end else if (!resp_valid) begin
        check("idle_resp_zero", {32'h0, resp_data}, 64'h0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request; call right after an active edge. Reads queue their expected data.
  task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [DW-1:0] exp);
    int n = 0;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_data  = d;
    @(negedge clk);
    while (!req_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      check("req_ready_timeout", 64'h0, 64'h1);
    end else begin
      check("fire_port", {23'h0, csb0, web0, addr0, din0},
            {23'h0, 1'b0, ~w, a, (w ? d : 32'h0)});
      if (!w) exp_q.push_back(exp);
      if (fire_first < 0) fire_first = cyc;
      fire_last = cyc;
    end
    step();
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_data  = '0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      step();
      n++;
    end
    check("drain", {32'h0, 32'(exp_q.size())}, 64'h0);
    step();
  endtask

  task automatic init_sweep(input string name);
    for (int i = 0; i < 128; i++) begin
      @(negedge clk);
      check(name, {21'h0, init_busy, csb0, web0, addr0, din0, req_ready},
            {21'h0, 1'b1, 1'b0, 1'b0, 7'(i), 32'h0, 1'b0});
      step();
    end
    @(negedge clk);
    check("init_done", {62'h0, init_busy, req_ready}, {62'h0, 1'b0, 1'b1});
    step();
  endtask

  initial begin
    // Reset behaviour.
    step();
    step();
    @(negedge clk);
    check("reset_port", {62'h0, csb0, web0}, {62'h0, 1'b1, 1'b1});
    check("reset_resp", {31'h0, resp_valid, resp_data}, 64'h0);
    check("reset_ready", {63'h0, req_ready}, 64'h0);
    step();
    reset = 1'b0;
    init_sweep("init_sweep");

    // Write then immediate read of the same word: latency 2.
    issue(1'b1, 7'd5, 32'hDEAD_BEEF, 32'h0);
    issue(1'b0, 7'd5, 32'h0, 32'hDEAD_BEEF);
    @(negedge clk);
    check("lat_n1_valid", {63'h0, resp_valid}, 64'h0);
    step();
    @(negedge clk);
    check("lat_n2", {31'h0, resp_valid, resp_data}, {31'h0, 1'b1, 32'hDEAD_BEEF});
    step();

    // Cleared word reads zero.
    issue(1'b0, 7'd100, 32'h0, 32'h0);
    drain();

    // Backpressure: two reads accepted, third held until the consumer drains.
    issue(1'b1, 7'd1, 32'h11, 32'h0);
    issue(1'b1, 7'd2, 32'h22, 32'h0);
    issue(1'b1, 7'd3, 32'h33, 32'h0);
    resp_ready = 1'b0;
    issue(1'b0, 7'd1, 32'h0, 32'h11);
    issue(1'b0, 7'd2, 32'h0, 32'h22);
    req_valid = 1'b1;
    req_addr  = 7'd3;
    @(negedge clk);
    check("hold_third_a", {63'h0, req_ready}, 64'h0);
    step();
    @(negedge clk);
    check("hold_third_b", {63'h0, req_ready}, 64'h0);
    step();
    resp_ready = 1'b1;
    issue(1'b0, 7'd3, 32'h0, 32'h33);
    drain();

    // Sustained one-read-per-cycle streaming.
    for (int i = 0; i < 16; i++) issue(1'b1, 7'(16 + i), 32'hA5A5_0000 + 32'(i), 32'h0);
    step();
    pop_cyc_q.delete();
    fire_first = -1;
    for (int i = 0; i < 16; i++) issue(1'b0, 7'(16 + i), 32'h0, 32'hA5A5_0000 + 32'(i));
    check("burst_fire_span", 64'(fire_last - fire_first), 64'd15);
    drain();
    check("burst_resp_count", 64'(pop_cyc_q.size()), 64'd16);
    if (pop_cyc_q.size() == 16) begin
      check("burst_resp_span", 64'(pop_cyc_q[15] - pop_cyc_q[0]), 64'd15);
    end

    // Reset with two responses pending discards them and restarts the clear.
    resp_ready = 1'b0;
    issue(1'b0, 7'd16, 32'h0, 32'h0);
    issue(1'b0, 7'd17, 32'h0, 32'h0);
    step();
    step();
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("midreset_port", {62'h0, csb0, web0}, {62'h0, 1'b1, 1'b1});
    step();
    reset = 1'b0;
    init_sweep("reinit_sweep");
    resp_ready = 1'b1;
    issue(1'b0, 7'd5, 32'h0, 32'h0);
    issue(1'b0, 7'd16, 32'h0, 32'h0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

endmodule

// File: doc/sram_port_ctrl.md
SRAM_PORT_CTRL -- requirements
Module: sram_port_ctrl

Interface
REQ-001 Parameters SHALL be: ADDR_W, 7, SRAM address width; DATA_W, 32, SRAM data width; DEPTH, 128, SRAM words; INIT_EN, 1, clear memory after reset; INIT_VALUE, 0, word written during clear.
REQ-002 clock  in  1  the one clock; the SRAM clk0 is tied to this same clock at the parent level.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 io_req_valid  in  1  request present.
REQ-005 io_req_ready  out  1  request accepted when high together with valid (fire).
REQ-006 io_req_write  in  1  1 = write, 0 = read.
REQ-007 io_req_addr  in  ADDR_W  word address.
REQ-008 io_req_data  in  DATA_W  write data; ignored for reads.
REQ-009 io_resp_valid  out  1  read data available.
REQ-010 io_resp_ready  in  1  consumer takes read data.
REQ-011 io_resp_data  out  DATA_W  read data; 0 when io_resp_valid is 0.
REQ-012 io_init_busy  out  1  clear sequence running.
REQ-013 io_sram_csb0 / io_sram_web0  out  1 each  active-low chip select / write enable to the SRAM.
REQ-014 io_sram_addr0  out  ADDR_W; io_sram_din0  out  DATA_W; io_sram_dout0  in  DATA_W.

Function
REQ-015 FSM states SHALL be INIT and RUN; reset enters INIT if INIT_EN=1, otherwise RUN.
REQ-016 INIT: each cycle drive csb0=0, web0=0, addr0=init counter, din0=INIT_VALUE; counter runs 0..DEPTH-1, then state goes to RUN with no idle cycle; io_init_busy=1 only in INIT.
REQ-017 io_req_ready SHALL be 1 only in RUN and when (fifo occupancy + read in flight - pop this cycle) < 2; it does not depend on io_req_write.
REQ-018 In a fire cycle, SRAM port is driven combinationally: csb0=0, web0=~io_req_write, addr0=io_req_addr, din0=io_req_data (din0=0 for reads).
REQ-019 Non-fire RUN cycles SHALL drive csb0=1, web0=1, addr0=0, din0=0.
REQ-020 Read fired in cycle N: in-flight flag set in N+1; io_sram_dout0 captured into the response FIFO at the end of N+1; io_resp_valid=1 in N+2 at the earliest (latency 2).
REQ-021 Writes produce no response; write followed by read of the same address in the next cycle SHALL return the new data.
REQ-022 Response FIFO: 2 entries, strict order; a pop occurs when io_resp_valid && io_resp_ready; simultaneous push and pop keeps occupancy; push never meets a full FIFO (guaranteed by REQ-017).
REQ-023 Back-to-back reads with io_resp_ready=1 SHALL sustain one read per cycle.

Reset
REQ-024 While reset is high, csb0=1 and web0=1 are forced.
REQ-025 After reset: state per REQ-015, init counter 0, FIFO empty, in-flight cleared, io_resp_valid=0, io_resp_data=0, io_req_ready=0 (INIT_EN=1).
REQ-026 Reset mid-operation discards pending and in-flight reads and restarts the clear sequence at address 0.

Structure
REQ-027 Package sram_ctrl_pkg SHALL hold ADDR_W, DATA_W, DEPTH defaults and the state enum {INIT, RUN}.
REQ-028 The response buffer SHALL be a separate sub-module resp_fifo2 (2-entry, valid/ready pop, occupancy output).

Verification
REQ-029 Release reset, INIT_EN=1 -> io_init_busy high exactly 128 cycles, addr0 sweeps 0..127 with csb0=0, web0=0, din0=0; io_req_ready=1 in cycle 129.
REQ-030 Write addr 5 data 0xDEADBEEF, read addr 5 next cycle (fire N) -> io_resp_valid=1 and io_resp_data=0xDEADBEEF in N+2.
REQ-031 Read addr 100 after init, with no prior write -> io_resp_data=0x00000000.
REQ-032 io_resp_ready=0, reads to 1,2,3 back-to-back (written 0x11,0x22,0x33) -> two fire, io_req_ready=0 holds the third; raise io_resp_ready -> 0x11,0x22,0x33 returned in order.
REQ-033 16 consecutive reads with io_resp_ready=1 -> 16 fires in 16 cycles, 16 responses in consecutive cycles.
REQ-034 Assert reset for one cycle while 2 responses are pending -> io_resp_valid=0 next cycle, io_init_busy=1, addr0=0.
